// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the PC source unit: FSM state encoding,
// well-known source indices and the select-width helper.
package pc_unit_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_e;

    localparam int unsigned SRC_ALU     = 0;
    localparam int unsigned SRC_ALU_RES = 1;
    localparam int unsigned SRC_A       = 2;
    localparam int unsigned SRC_CONCAT  = 3;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_src_mux_n.sv
// N-way next-PC source selector; out-of-range selects fall back to the ALU source.
module pc_src_mux_n
    import pc_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned SEL_W  = sel_width(NUM_SRC)
) (
    input  logic [WIDTH*NUM_SRC-1:0] src_bus_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [WIDTH-1:0]         y_o
);

    always_comb begin
        y_o = src_bus_i[SRC_ALU*WIDTH +: WIDTH];
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (32'(sel_i) == i) begin
                y_o = src_bus_i[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_source_unit.sv
// Program counter with selectable next-PC source and branch-qualified write.
// Define PC_ALIGN_CHECK_EN to enable the misalignment trap (RUN/TRAP FSM).
module pc_source_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter int unsigned     NUM_SRC  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'('h80),
    localparam int unsigned    SEL_W    = sel_width(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH*NUM_SRC-1:0] src_bus,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     zero,
    input  logic                     err_clear,
    output logic [WIDTH-1:0]         next_pc,
    output logic [WIDTH-1:0]         pc,
    output logic                     pc_updated,
    output logic [WIDTH-1:0]         epc,
    output logic                     misalign_err,
    output logic                     trapped
);

    logic             we;
    logic [WIDTH-1:0] pc_q;
    logic             upd_q;

    assign we = pc_write | (pc_write_cond & zero);

    pc_src_mux_n #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) u_mux (
        .src_bus_i (src_bus),
        .sel_i     (src_sel),
        .y_o       (next_pc)
    );

    assign pc         = pc_q;
    assign pc_updated = upd_q;

`ifdef PC_ALIGN_CHECK_EN
    pc_state_e        state_q;
    logic [WIDTH-1:0] epc_q;
    logic             err_q;
    logic             misalign;

    assign misalign = we && (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            upd_q   <= 1'b0;
            epc_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (err_clear) begin
                        err_q <= 1'b0;
                    end
                    // A misaligned write diverts to the trap vector on the same edge.
                    if (misalign) begin
                        epc_q   <= pc_q;
                        err_q   <= 1'b1;
                        pc_q    <= TRAP_VEC;
                        upd_q   <= 1'b1;
                        state_q <= TRAP;
                    end else if (we) begin
                        pc_q  <= next_pc;
                        upd_q <= 1'b1;
                    end
                end
                TRAP: begin
                    pc_q <= TRAP_VEC;
                    if (err_clear) begin
                        err_q   <= 1'b0;
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

    assign epc          = epc_q;
    assign misalign_err = err_q;
    assign trapped      = (state_q == TRAP);
`else
    logic unused_err_clear;

    assign unused_err_clear = err_clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            upd_q <= 1'b0;
        end else begin
            upd_q <= we;
            if (we) begin
                pc_q <= next_pc;
            end
        end
    end

    assign epc          = '0;
    assign misalign_err = 1'b0;
    assign trapped      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_source_unit.sv
// Table-driven bench for pc_source_unit (NUM_SRC=4 and NUM_SRC=3 instances),
// with hand sequences for the trap / wrap-around corner cases.
module tb_pc_source_unit;

    logic         clk;
    logic         reset;
    logic [127:0] src_bus;
    logic [95:0]  src_bus3;
    logic [1:0]   src_sel;
    logic         pc_write;
    logic         pc_write_cond;
    logic         zero;
    logic         err_clear;

    logic [31:0]  next_pc, pc, epc;
    logic         pc_updated, misalign_err, trapped;
    logic [31:0]  next_pc3, pc3, epc3;
    logic         pc_updated3, misalign_err3, trapped3;

    int n_assert = 0;
    int n_fail   = 0;

    pc_source_unit #(
        .WIDTH   (32),
        .NUM_SRC (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_bus       (src_bus),
        .src_sel       (src_sel),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .err_clear     (err_clear),
        .next_pc       (next_pc),
        .pc            (pc),
        .pc_updated    (pc_updated),
        .epc           (epc),
        .misalign_err  (misalign_err),
        .trapped       (trapped)
    );

    pc_source_unit #(
        .WIDTH   (32),
        .NUM_SRC (3)
    ) dut3 (
        .clk           (clk),
        .reset         (reset),
        .src_bus       (src_bus3),
        .src_sel       (src_sel),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .err_clear     (err_clear),
        .next_pc       (next_pc3),
        .pc            (pc3),
        .pc_updated    (pc_updated3),
        .epc           (epc3),
        .misalign_err  (misalign_err3),
        .trapped       (trapped3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic        pw;
        logic        pwc;
        logic        z;
        logic [31:0] nxt;
        logic [31:0] nxt3;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc3;
        logic        upd;
        logic        upd3;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc3;
        logic        upd;
        logic        upd3;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        zero          = 1'b0;
        err_clear     = 1'b0;
    endtask

    initial begin
        exp_t e;

        // source0=0x8, source1=0x4, source2=0x10, source3=0x20
        src_bus  = {32'h20, 32'h10, 32'h4, 32'h8};
        src_bus3 = {32'h10, 32'h4, 32'h8};
        src_sel  = 2'd0;
        idle_inputs();
        reset    = 1'b1;

        //          sel   pw    pwc   z     nxt     nxt3    pc      pc3     upd   upd3
        vecs[0] = '{2'd2, 1'b1, 1'b0, 1'b0, 32'h10, 32'h10, 32'h10, 32'h10, 1'b1, 1'b1};
        vecs[1] = '{2'd1, 1'b0, 1'b0, 1'b0, 32'h04, 32'h04, 32'h10, 32'h10, 1'b0, 1'b0};
        vecs[2] = '{2'd1, 1'b0, 1'b1, 1'b0, 32'h04, 32'h04, 32'h10, 32'h10, 1'b0, 1'b0};
        vecs[3] = '{2'd1, 1'b0, 1'b1, 1'b1, 32'h04, 32'h04, 32'h04, 32'h04, 1'b1, 1'b1};
        vecs[4] = '{2'd3, 1'b1, 1'b0, 1'b0, 32'h20, 32'h08, 32'h20, 32'h08, 1'b1, 1'b1};
        vecs[5] = '{2'd0, 1'b1, 1'b1, 1'b0, 32'h08, 32'h08, 32'h08, 32'h08, 1'b1, 1'b1};
        vecs[6] = '{2'd0, 1'b0, 1'b0, 1'b1, 32'h08, 32'h08, 32'h08, 32'h08, 1'b0, 1'b0};
        vecs[7] = '{2'd2, 1'b1, 1'b1, 1'b1, 32'h10, 32'h10, 32'h10, 32'h10, 1'b1, 1'b1};
        vecs[8] = '{2'd3, 1'b0, 1'b0, 1'b1, 32'h20, 32'h08, 32'h10, 32'h10, 1'b0, 1'b0};

        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_upd", {31'b0, pc_updated}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'h0);
        chk("rst_trapped", {31'b0, trapped}, 32'h0);

        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle%0d_pc", i), pc, 32'h0);
            chk($sformatf("idle%0d_upd", i), {31'b0, pc_updated}, 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            src_sel       = vecs[i].sel;
            pc_write      = vecs[i].pw;
            pc_write_cond = vecs[i].pwc;
            zero          = vecs[i].z;
            sb.push_back('{vecs[i].exp_pc, vecs[i].exp_pc3, vecs[i].upd, vecs[i].upd3});
            #1;
            chk($sformatf("v%0d_next_pc", i), next_pc, vecs[i].nxt);
            chk($sformatf("v%0d_next_pc3", i), next_pc3, vecs[i].nxt3);
            step();
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_pc", i), pc, e.pc);
                chk($sformatf("v%0d_pc3", i), pc3, e.pc3);
                chk($sformatf("v%0d_upd", i), {31'b0, pc_updated}, {31'b0, e.upd});
                chk($sformatf("v%0d_upd3", i), {31'b0, pc_updated3}, {31'b0, e.upd3});
            end
        end
        idle_inputs();
        step();
        chk("after_tbl_upd", {31'b0, pc_updated}, 32'h0);

`ifdef PC_ALIGN_CHECK_EN
        src_bus   = {32'h20, 32'h10, 32'h4, 32'h6};
        src_sel   = 2'd0;
        pc_write  = 1'b1;
        #1;
        chk("mis_next_pc", next_pc, 32'h6);
        step();
        chk("trap_pc", pc, 32'h80);
        chk("trap_epc", epc, 32'h10);
        chk("trap_err", {31'b0, misalign_err}, 32'h1);
        chk("trap_trapped", {31'b0, trapped}, 32'h1);
        chk("trap_upd", {31'b0, pc_updated}, 32'h1);

        src_sel = 2'd2;
        step();
        chk("trap_ign_pc", pc, 32'h80);
        chk("trap_ign_upd", {31'b0, pc_updated}, 32'h0);
        chk("trap_ign_trapped", {31'b0, trapped}, 32'h1);

        pc_write  = 1'b0;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("clr_trapped", {31'b0, trapped}, 32'h0);
        chk("clr_err", {31'b0, misalign_err}, 32'h0);
        chk("clr_epc", epc, 32'h10);
        chk("clr_pc", pc, 32'h80);

        src_sel  = 2'd2;
        pc_write = 1'b1;
        step();
        chk("resume_pc", pc, 32'h10);
        chk("resume_upd", {31'b0, pc_updated}, 32'h1);

        src_sel = 2'd0;
        step();
        chk("trap2_trapped", {31'b0, trapped}, 32'h1);

        reset     = 1'b1;
        err_clear = 1'b1;
        step();
        chk("rst_trap_pc", pc, 32'h0);
        chk("rst_trap_trapped", {31'b0, trapped}, 32'h0);
        chk("rst_trap_epc", epc, 32'h0);
        chk("rst_trap_err", {31'b0, misalign_err}, 32'h0);
        reset = 1'b0;
        idle_inputs();
`else
        src_bus  = {32'hFFFF_FFFF, 32'h10, 32'h4, 32'h6};
        src_sel  = 2'd3;
        pc_write = 1'b1;
        step();
        chk("wrap_pc", pc, 32'hFFFF_FFFF);
        chk("wrap_upd", {31'b0, pc_updated}, 32'h1);

        pc_write  = 1'b0;
        err_clear = 1'b1;
        step();
        chk("noalign_hold_pc", pc, 32'hFFFF_FFFF);
        chk("noalign_trapped", {31'b0, trapped}, 32'h0);

        err_clear = 1'b0;
        src_sel   = 2'd0;
        pc_write  = 1'b1;
        step();
        chk("noalign_mis_pc", pc, 32'h6);
        chk("noalign_err", {31'b0, misalign_err}, 32'h0);
        chk("noalign_epc", epc, 32'h0);
        chk("noalign_trapped2", {31'b0, trapped}, 32'h0);

        reset = 1'b1;
        step();
        chk("rst_again_pc", pc, 32'h0);
        chk("rst_again_upd", {31'b0, pc_updated}, 32'h0);
        reset = 1'b0;
        idle_inputs();
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_source_unit.md
PC_SOURCE_UNIT -- requirements
Module: pc_source_unit

Interface
REQ-001 Parameter WIDTH, default 32, is the PC and source width in bits (>=8).
REQ-002 Parameter NUM_SRC, default 4, is the number of candidate next-PC sources (2..16).
REQ-003 Parameter RESET_PC, default 0, is the PC value loaded on reset.
REQ-004 Parameter TRAP_VEC, default 32'h80, is the PC value loaded on a misalignment trap.
REQ-005 Derived constant SEL_W SHALL equal max(1, clog2(NUM_SRC)).
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 src_bus  input  WIDTH*NUM_SRC  packed sources; source i at bits [i*WIDTH +: WIDTH]; source 0 = ALU, 1 = ALU result register, 2 = A register, 3 = jump concat.
REQ-009 src_sel  input  SEL_W  selects the next-PC source.
REQ-010 pc_write  input  1  unconditional PC update request.
REQ-011 pc_write_cond  input  1  conditional PC update request (branch).
REQ-012 zero  input  1  ALU zero flag that qualifies pc_write_cond.
REQ-013 err_clear  input  1  clears trap state and error flag.
REQ-014 next_pc  output  WIDTH  combinational selected source.
REQ-015 pc  output  WIDTH  registered program counter.
REQ-016 pc_updated  output  1  one-cycle pulse, high the cycle after pc loads a new value.
REQ-017 epc  output  WIDTH  PC value captured at the last trap.
REQ-018 misalign_err  output  1  sticky misalignment flag.
REQ-019 trapped  output  1  high while the FSM is in TRAP.

Function
REQ-020 next_pc SHALL equal source src_sel; src_sel >= NUM_SRC SHALL select source 0.
REQ-021 Write enable we SHALL be pc_write OR (pc_write_cond AND zero), evaluated each cycle.
REQ-022 FSM states: RUN, TRAP; reset state RUN.
REQ-023 In RUN with we=1 and no misalignment, pc SHALL load next_pc on the next edge (latency 1 cycle).
REQ-024 In RUN with we=0, pc SHALL hold.
REQ-025 In TRAP, all writes SHALL be ignored and pc SHALL hold TRAP_VEC.
REQ-026 TRAP -> RUN SHALL occur on err_clear=1; this clears misalign_err and leaves epc unchanged.
REQ-027 err_clear in RUN SHALL only clear misalign_err.
REQ-028 pc_updated SHALL pulse once for each edge where pc loaded next_pc or TRAP_VEC.
REQ-029 pc_write and pc_write_cond both high SHALL behave as pc_write alone.
REQ-030 Wrap-around: next_pc of all-ones SHALL load unchanged, with no saturation.

Reset
REQ-031 On reset: pc=RESET_PC, epc=0, misalign_err=0, trapped=0, pc_updated=0, state=RUN.
REQ-032 Reset SHALL take priority over we and err_clear, including mid-trap.

Configuration
REQ-033 With PC_ALIGN_CHECK_EN defined: in RUN, if we=1 and next_pc[1:0]!=0, the unit SHALL set epc=pc, misalign_err=1, pc=TRAP_VEC, and state=TRAP on the same edge.
REQ-034 With PC_ALIGN_CHECK_EN undefined: no alignment check; misalign_err, trapped and epc SHALL be constant 0; err_clear is ignored; the FSM SHALL stay in RUN.

Structure
REQ-035 Package pc_unit_pkg SHALL hold the FSM state enum (RUN, TRAP) and the source index constants SRC_ALU=0, SRC_ALU_RES=1, SRC_A=2, SRC_CONCAT=3.
REQ-036 The source selection SHALL be a sub-module pc_src_mux_n (parameters WIDTH, NUM_SRC); all state SHALL live in pc_source_unit.

Verification
REQ-037 Reset then idle: pc=0, pc_updated=0 for 5 cycles.
REQ-038 src_bus sources = {0x8,0x4,0x10,0x20}, src_sel=2, pc_write=1 for 1 cycle -> pc=0x10 next cycle; pc_updated pulses once.
REQ-039 pc_write_cond=1 with zero=0 -> pc holds; with zero=1 and src_sel=1 -> pc=0x4.
REQ-040 src_sel=3 (0x20) with NUM_SRC=3 -> source 0 selected, so pc=0x8.
REQ-041 PC_ALIGN_CHECK_EN defined, pc=0x10, source=0x6, pc_write=1 -> pc=0x80, epc=0x10, misalign_err=1, trapped=1; further writes ignored; err_clear -> trapped=0, misalign_err=0.
REQ-042 Assert reset while trapped -> next cycle pc=RESET_PC, trapped=0, epc=0.
